display_bcd_scheduler: RTL and testbench

Shares a single binary-to-BCD converter between the minutes and seconds channels of the display path, replacing one dedicated converter per channel. It detects which channel value has changed, grants the converter by round-robin, and runs a start/done handshake with a timeout. It commits validated BCD digits into four held digit registers, which feed the per-digit seven-segment decoders and the 4-digit multiplexing driver.

---
 rtl/display_pkg.sv | 28 ++
 rtl/display_bcd_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_display_bcd_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the display BCD scheduler.
//   sched_state_t : scheduler FSM states
//   chan_t        : display channel identifiers
//   BCD_W         : converter result width (four nibbles)
//   DEFAULT_TIMEOUT : default WAIT-state abort limit in cycles
//   bcd_valid()   : range check on a converter result
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } sched_state_t;

    typedef enum logic {
        CH_MIN,
        CH_SEC
    } chan_t;

    localparam int unsigned BCD_W           = 16;
    localparam int unsigned DEFAULT_TIMEOUT = 63;

    // A usable two-digit result has an empty high byte and decimal low nibbles.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] bcd);
        return (bcd[15:8] == 8'd0) && (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/display_bcd_scheduler.sv
// Time-shares one binary-to-BCD converter between the minutes and seconds
// channels and holds the four resulting display digits.
//   clk, rst_n          : clock, asynchronous active-low reset
//   minutes, seconds    : channel values (0-59 expected)
//   conv_start          : one-cycle converter request
//   conv_bin            : converter operand, stable from ISSUE through WAIT
//   conv_done, conv_bcd : converter completion pulse and result
//   bcd0, bcd1          : seconds ones / tens digits
//   bcd2, bcd3          : minutes ones / tens digits
//   disp_update         : one-cycle pulse after a digit commit
//   conv_err            : one-cycle pulse on timeout or invalid result
module display_bcd_scheduler
    import display_pkg::*;
#(
    parameter int unsigned BIN_W   = 6,
    parameter int unsigned CONV_W  = 14,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  minutes,
    input  logic [BIN_W-1:0]  seconds,
    output logic              conv_start,
    output logic [CONV_W-1:0] conv_bin,
    input  logic              conv_done,
    input  logic [BCD_W-1:0]  conv_bcd,
    output logic [3:0]        bcd0,
    output logic [3:0]        bcd1,
    output logic [3:0]        bcd2,
    output logic [3:0]        bcd3,
    output logic              disp_update,
    output logic              conv_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t      state_q,       state_d;
    logic [BIN_W-1:0]  last_min_q,    last_min_d;
    logic [BIN_W-1:0]  last_sec_q,    last_sec_d;
    logic              force_min_q,   force_min_d;
    logic              force_sec_q,   force_sec_d;
    chan_t             last_grant_q,  last_grant_d;
    chan_t             grant_q,       grant_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [CONV_W-1:0] conv_bin_q,    conv_bin_d;
    logic              conv_start_q,  conv_start_d;
    logic [3:0]        bcd0_q,        bcd0_d;
    logic [3:0]        bcd1_q,        bcd1_d;
    logic [3:0]        bcd2_q,        bcd2_d;
    logic [3:0]        bcd3_q,        bcd3_d;
    logic              disp_update_q, disp_update_d;
    logic              conv_err_q,    conv_err_d;

    logic  pend_min_c;
    logic  pend_sec_c;
    chan_t sel_c;

    // A channel needs work when forced or when it differs from its last issued value.
    assign pend_min_c = force_min_q | (minutes != last_min_q);
    assign pend_sec_c = force_sec_q | (seconds != last_sec_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        last_min_d    = last_min_q;
        last_sec_d    = last_sec_q;
        force_min_d   = force_min_q;
        force_sec_d   = force_sec_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        cnt_d         = cnt_q;
        conv_bin_d    = conv_bin_q;
        conv_start_d  = 1'b0;
        bcd0_d        = bcd0_q;
        bcd1_d        = bcd1_q;
        bcd2_d        = bcd2_q;
        bcd3_d        = bcd3_q;
        disp_update_d = 1'b0;
        conv_err_d    = 1'b0;
        sel_c         = CH_MIN;

        case (state_q)
            IDLE: begin
                if (pend_min_c || pend_sec_c) begin
                    // Round-robin only matters when both channels compete.
                    if (pend_min_c && pend_sec_c) begin
                        sel_c = (last_grant_q == CH_MIN) ? CH_SEC : CH_MIN;
                    end else begin
                        sel_c = pend_sec_c ? CH_SEC : CH_MIN;
                    end
                    grant_d      = sel_c;
                    last_grant_d = sel_c;
                    if (sel_c == CH_SEC) begin
                        conv_bin_d  = CONV_W'(seconds);
                        last_sec_d  = seconds;
                        force_sec_d = 1'b0;
                    end else begin
                        conv_bin_d  = CONV_W'(minutes);
                        last_min_d  = minutes;
                        force_min_d = 1'b0;
                    end
                    conv_start_d = 1'b1;
                    state_d      = ISSUE;
                end
            end

            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end

            WAIT: begin
                if (conv_done) begin
                    // Invalid results keep the snapshot, so they are not retried.
                    if (bcd_valid(conv_bcd)) begin
                        if (grant_q == CH_SEC) begin
                            bcd1_d = conv_bcd[7:4];
                            bcd0_d = conv_bcd[3:0];
                        end else begin
                            bcd3_d = conv_bcd[7:4];
                            bcd2_d = conv_bcd[3:0];
                        end
                        disp_update_d = 1'b1;
                    end else begin
                        conv_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abort on the TIMEOUT-th WAIT cycle and force a retry.
                    conv_err_d = 1'b1;
                    if (grant_q == CH_SEC) begin
                        force_sec_d = 1'b1;
                    end else begin
                        force_min_d = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_min_q    <= '0;
            last_sec_q    <= '0;
            force_min_q   <= 1'b1;
            force_sec_q   <= 1'b1;
            last_grant_q  <= CH_MIN;
            grant_q       <= CH_MIN;
            cnt_q         <= '0;
            conv_bin_q    <= '0;
            conv_start_q  <= 1'b0;
            bcd0_q        <= 4'd0;
            bcd1_q        <= 4'd0;
            bcd2_q        <= 4'd0;
            bcd3_q        <= 4'd0;
            disp_update_q <= 1'b0;
            conv_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_min_q    <= last_min_d;
            last_sec_q    <= last_sec_d;
            force_min_q   <= force_min_d;
            force_sec_q   <= force_sec_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            conv_bin_q    <= conv_bin_d;
            conv_start_q  <= conv_start_d;
            bcd0_q        <= bcd0_d;
            bcd1_q        <= bcd1_d;
            bcd2_q        <= bcd2_d;
            bcd3_q        <= bcd3_d;
            disp_update_q <= disp_update_d;
            conv_err_q    <= conv_err_d;
        end
    end

    assign conv_start  = conv_start_q;
    assign conv_bin    = conv_bin_q;
    assign bcd0        = bcd0_q;
    assign bcd1        = bcd1_q;
    assign bcd2        = bcd2_q;
    assign bcd3        = bcd3_q;
    assign disp_update = disp_update_q;
    assign conv_err    = conv_err_q;

endmodule

// File: tb/tb_display_bcd_scheduler.sv
// Bench for display_bcd_scheduler: behavioural converter, event monitor,
// directed scenarios followed by randomized value changes checked against
// decimal arithmetic on the final channel values.
module tb_display_bcd_scheduler;
    import display_pkg::*;

    localparam int unsigned BIN_W   = 6;
    localparam int unsigned CONV_W  = 14;
    localparam int unsigned TIMEOUT = 63;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [BIN_W-1:0]  minutes = '0;
    logic [BIN_W-1:0]  seconds = '0;
    logic              conv_start;
    logic [CONV_W-1:0] conv_bin;
    logic              conv_done = 1'b0;
    logic [BCD_W-1:0]  conv_bcd = 16'hFFFF;
    logic [3:0]        bcd0, bcd1, bcd2, bcd3;
    logic              disp_update;
    logic              conv_err;

    int vectors = 0;
    int miscompares = 0;

    display_bcd_scheduler #(
        .BIN_W   (BIN_W),
        .CONV_W  (CONV_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .minutes     (minutes),
        .seconds     (seconds),
        .conv_start  (conv_start),
        .conv_bin    (conv_bin),
        .conv_done   (conv_done),
        .conv_bcd    (conv_bcd),
        .bcd0        (bcd0),
        .bcd1        (bcd1),
        .bcd2        (bcd2),
        .bcd3        (bcd3),
        .disp_update (disp_update),
        .conv_err    (conv_err)
    );

    always #5 clk = ~clk;

    // Converter model: mode 0 correct, 1 never answers, 2 returns 16'h0107.
    int lat = 4;
    int mode = 0;
    int cdown = 0;
    int job_bin = 0;
    logic spur = 1'b0;

    function automatic logic [15:0] to_bcd(input int v);
        return {8'h00, 4'(v / 10), 4'(v % 10)};
    endfunction

    always @(negedge clk) begin
        conv_done = 1'b0;
        conv_bcd  = 16'hFFFF;
        if (!rst_n) begin
            cdown = 0;
        end else begin
            if (spur) begin
                conv_done = 1'b1;
                conv_bcd  = 16'h0099;
            end
            if (cdown > 0) begin
                cdown--;
                if (cdown == 0) begin
                    conv_done = 1'b1;
                    conv_bcd  = (mode == 2) ? 16'h0107 : to_bcd(job_bin);
                end
            end
            if (conv_start && mode != 1) begin
                cdown   = lat;
                job_bin = int'(conv_bin);
            end
        end
    end

    // Event monitor.
    int cyc = 0;
    int quiet = 0;
    bit outstanding = 1'b0;
    int start_cnt = 0, disp_cnt = 0, err_cnt = 0;
    int first_start = -1, first_disp = -1, first_err = -1;
    int bin_q[$];
    int commit_q[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (conv_start) begin
                bin_q.push_back(int'(conv_bin));
                start_cnt++;
                if (first_start < 0) first_start = cyc;
                outstanding = 1'b1;
            end
            if (disp_update) begin
                commit_q.push_back(int'({bcd3, bcd2, bcd1, bcd0}));
                disp_cnt++;
                if (first_disp < 0) first_disp = cyc;
                outstanding = 1'b0;
            end
            if (conv_err) begin
                err_cnt++;
                if (first_err < 0) first_err = cyc;
                outstanding = 1'b0;
            end
        end
        if (conv_start || outstanding) quiet = 0;
        else quiet++;
    end

    task automatic clear_log();
        bin_q.delete();
        commit_q.delete();
        start_cnt = 0;
        disp_cnt = 0;
        err_cnt = 0;
        first_start = -1;
        first_disp = -1;
        first_err = -1;
        quiet = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check_digits(input string tag, input int m, input int s);
        check({tag, " bcd3"}, 32'(bcd3), 32'(m / 10));
        check({tag, " bcd2"}, 32'(bcd2), 32'(m % 10));
        check({tag, " bcd1"}, 32'(bcd1), 32'(s / 10));
        check({tag, " bcd0"}, 32'(bcd0), 32'(s % 10));
    endtask

    // Wait for the scheduler to go quiet; an expired budget counts as a miscompare.
    task automatic settle(input string tag);
        int n;
        n = 0;
        tick(3);
        while ((outstanding || quiet < 8) && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) check({tag, " settle"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_starts(input string tag, input int k, input int budget);
        int n;
        n = 0;
        while (start_cnt < k && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check({tag, " start wait"}, 32'(start_cnt), 32'(k));
    endtask

    initial begin
        int c0;
        int m, s;

        // Reset values.
        tick(3);
        check("rst conv_start", 32'(conv_start), 32'd0);
        check("rst conv_bin", 32'(conv_bin), 32'd0);
        check("rst digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'd0);
        check("rst disp_update", 32'(disp_update), 32'd0);
        check("rst conv_err", 32'(conv_err), 32'd0);

        // Forced conversion of both channels after reset release.
        clear_log();
        rst_n = 1'b1;
        settle("boot");
        check("boot starts", 32'(start_cnt), 32'd2);
        check("boot updates", 32'(disp_cnt), 32'd2);
        check("boot errs", 32'(err_cnt), 32'd0);
        check("boot digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'd0);

        // Seconds granted first after reset (distinct values expose the order).
        rst_n = 1'b0;
        tick(2);
        minutes = 6'd12;
        seconds = 6'd37;
        clear_log();
        rst_n = 1'b1;
        settle("order");
        check("order first", 32'(q_at(bin_q, 0)), 32'd37);
        check("order second", 32'(q_at(bin_q, 1)), 32'd12);
        check_digits("order", 12, 37);

        // Single-channel change: one job, grant and commit latency.
        clear_log();
        c0 = cyc;
        seconds = 6'd38;
        settle("sec38");
        check("sec38 starts", 32'(start_cnt), 32'd1);
        check("sec38 bin", 32'(q_at(bin_q, 0)), 32'd38);
        check("sec38 start lat", 32'(first_start - c0), 32'd2);
        check("sec38 disp lat", 32'(first_disp - first_start), 32'(lat + 1));
        check("sec38 updates", 32'(disp_cnt), 32'd1);
        check_digits("sec38", 12, 38);

        // Both change together; the last grant was seconds, so minutes goes first.
        clear_log();
        minutes = 6'd59;
        seconds = 6'd45;
        settle("both");
        check("both first", 32'(q_at(bin_q, 0)), 32'd59);
        check("both second", 32'(q_at(bin_q, 1)), 32'd45);
        check("both updates", 32'(disp_cnt), 32'd2);
        check_digits("both", 59, 45);

        // Value changes during its own WAIT: stale result first, then the new one.
        clear_log();
        seconds = 6'd10;
        wait_starts("own", 1, 20);
        tick(1);
        seconds = 6'd11;
        settle("own");
        check("own bin0", 32'(q_at(bin_q, 0)), 32'd10);
        check("own bin1", 32'(q_at(bin_q, 1)), 32'd11);
        check("own commit0", 32'(q_at(commit_q, 0) & 32'hFF), 32'h10);
        check("own commit1", 32'(q_at(commit_q, 1) & 32'hFF), 32'h11);
        check_digits("own", 59, 11);

        // A done pulse outside WAIT changes nothing.
        clear_log();
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        tick(5);
        check("spur updates", 32'(disp_cnt), 32'd0);
        check("spur errs", 32'(err_cnt), 32'd0);
        check_digits("spur", 59, 11);

        // Silent converter: timeout error, digits held, same channel retried.
        clear_log();
        mode = 1;
        minutes = 6'd33;
        begin
            int n;
            n = 0;
            while (err_cnt == 0 && n < 200) begin
                tick(1);
                n++;
            end
            check("tmo seen", 32'(err_cnt > 0), 32'd1);
        end
        check("tmo latency", 32'(first_err - first_start), 32'(TIMEOUT + 1));
        check("tmo updates", 32'(disp_cnt), 32'd0);
        check_digits("tmo", 59, 11);
        wait_starts("tmo retry", 2, 10);
        check("tmo retry bin", 32'(q_at(bin_q, 1)), 32'd33);
        mode = 0;
        settle("tmo");
        check_digits("tmo recover", 33, 11);

        // Invalid result: error, no update, no retry.
        clear_log();
        mode = 2;
        seconds = 6'd20;
        settle("inv");
        mode = 0;
        tick(20);
        check("inv errs", 32'(err_cnt), 32'd1);
        check("inv updates", 32'(disp_cnt), 32'd0);
        check("inv starts", 32'(start_cnt), 32'd1);
        check_digits("inv", 33, 11);
        seconds = 6'd21;
        settle("inv recover");
        check_digits("inv recover", 33, 21);

        // Randomized value changes at random times and converter latencies.
        for (int it = 0; it < 25; it++) begin
            lat = int'($urandom_range(8, 1));
            for (int k = 0; k < int'($urandom_range(4, 1)); k++) begin
                if ($urandom_range(1, 0) == 1) minutes = 6'($urandom_range(59, 0));
                if ($urandom_range(1, 0) == 1) seconds = 6'($urandom_range(59, 0));
                tick(int'($urandom_range(8, 0)));
            end
            settle("rand");
            m = int'(minutes);
            s = int'(seconds);
            check_digits($sformatf("rand%0d", it), m, s);
        end

        // Reset in the middle of a job.
        lat = 4;
        clear_log();
        seconds = 6'((int'(seconds) + 1) % 60);
        wait_starts("midrst", 1, 20);
        rst_n = 1'b0;
        #1;
        check("midrst digits", 32'({bcd3, bcd2, bcd1, bcd0}), 32'd0);
        check("midrst conv_start", 32'(conv_start), 32'd0);
        check("midrst conv_bin", 32'(conv_bin), 32'd0);
        tick(2);
        clear_log();
        rst_n = 1'b1;
        settle("midrst");
        check("midrst starts", 32'(start_cnt), 32'd2);
        check_digits("midrst", int'(minutes), int'(seconds));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
